// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared FSM state type and framing constants for fifo_drain_tx (CSUM state exists only with FIFO_DRAIN_CSUM_EN)
package fifo_drain_pkg;
  localparam logic [7:0] PKT_HDR = 8'hA5;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    LOAD,
    BYTES
`ifdef FIFO_DRAIN_CSUM_EN
    , CSUM
`endif
  } state_t;
  function automatic int bytes_per_word(input int dw);
    return dw / BYTE_W;
  endfunction
endpackage

// File: rtl/fifo_drain_tx_if.sv
// fifo_drain_tx_if: FIFO read side, byte stream and status signals of fifo_drain_tx
interface fifo_drain_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_CNT_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic fifo_rdy;
  logic [FIFO_CNT_WIDTH-1:0] fifo_size;
  logic fifo_rd;
  logic drain_req;
  logic abort;
  logic [7:0] tx_data;
  logic tx_vld;
  logic tx_rdy;
  logic busy;
  logic pkt_done;
  logic pkt_abort;
  modport master (
    input fifo_data, fifo_rdy, fifo_size, drain_req, abort, tx_rdy,
    output fifo_rd, tx_data, tx_vld, busy, pkt_done, pkt_abort
  );
  modport slave (
    output fifo_data, fifo_rdy, fifo_size, drain_req, abort, tx_rdy,
    input fifo_rd, tx_data, tx_vld, busy, pkt_done, pkt_abort
  );
endinterface

// File: rtl/fifo_drain_tx_byte_serializer.sv
// byte_serializer: holds one word and presents it MSB byte first, advancing on each accepted byte
module byte_serializer
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            data,
  output logic                  last
);
  localparam int NB = bytes_per_word(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] sr;
  logic [7:0] idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      idx <= '0;
    end else if (load) begin
      sr <= word;
      idx <= '0;
    end else if (shift) begin
      sr <= sr << BYTE_W;
      idx <= idx + 8'd1;
    end
  end
  assign data = sr[DATA_WIDTH-1 -: 8];
  assign last = idx == 8'(NB - 1);
endmodule

// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: frames FIFO words into A5/N/payload packets on a byte valid/ready link
// FIFO_DRAIN_CSUM_EN appends an XOR-of-payload checksum byte to each packet
module fifo_drain_tx
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_CNT_WIDTH = 3,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst,
  fifo_drain_tx_if.master bus
);
  state_t state, state_n;
  logic [FIFO_CNT_WIDTH-1:0] size;
  logic [31:0] size_ext;
  logic [7:0] n_cnt, rem, n_new, ser_byte, csum_byte;
  logic trig, full, hs, last, shift, done_n, done_q, abort_q, csum_vld;
  assign size = bus.fifo_size;
  assign size_ext = 32'(size);
  assign full = size_ext >= 32'(BURST_LEN);
  assign trig = full || (bus.drain_req && bus.fifo_rdy);
  assign n_new = full ? 8'(BURST_LEN) : size_ext[7:0];
  assign hs = bus.tx_vld && bus.tx_rdy;
  assign shift = state == BYTES && hs && !bus.abort;
  // rst and abort gate the pop so no word is lost from the FIFO on a dropped packet
  assign bus.fifo_rd = state == LOAD && bus.fifo_rdy && !bus.abort && !rst;
  byte_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(bus.fifo_rd),
    .shift(shift),
    .word(bus.fifo_data),
    .data(ser_byte),
    .last(last)
  );
`ifdef FIFO_DRAIN_CSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && trig)) csum <= '0;
    else if (shift) csum <= csum ^ ser_byte;
  end
  assign csum_vld = state == CSUM;
  assign csum_byte = csum;
`else
  assign csum_vld = 1'b0;
  assign csum_byte = 8'h00;
`endif
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    case (state)
      IDLE: state_n = trig ? HDR : IDLE;
      HDR: state_n = hs ? CNT : HDR;
      CNT: state_n = hs ? LOAD : CNT;
      LOAD: state_n = bus.fifo_rdy ? BYTES : LOAD;
`ifdef FIFO_DRAIN_CSUM_EN
      BYTES: state_n = hs && last ? (rem != 8'd0 ? LOAD : CSUM) : BYTES;
      CSUM: begin
        state_n = hs ? IDLE : CSUM;
        done_n = hs;
      end
`else
      BYTES: begin
        state_n = hs && last ? (rem != 8'd0 ? LOAD : IDLE) : BYTES;
        done_n = hs && last && rem == 8'd0;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      done_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_cnt <= '0;
      rem <= '0;
      done_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= done_n;
      abort_q <= bus.abort && state != IDLE;
      if (state == IDLE && trig) begin
        n_cnt <= n_new;
        rem <= n_new;
      end else if (bus.fifo_rd) begin
        rem <= rem - 8'd1;
      end
    end
  end
  assign bus.tx_vld = state == HDR || state == CNT || state == BYTES || csum_vld;
  assign bus.tx_data = state == HDR ? PKT_HDR : state == CNT ? n_cnt : state == BYTES ? ser_byte : csum_vld ? csum_byte : 8'h00;
  assign bus.busy = state != IDLE;
  assign bus.pkt_done = done_q;
  assign bus.pkt_abort = abort_q;
endmodule

// File: tb/tb_fifo_drain_tx.sv
// tb_fifo_drain_tx: scoreboard bench for fifo_drain_tx with a small FIFO model feeding it
module tb_fifo_drain_tx;
`ifdef FIFO_DRAIN_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  fifo_drain_tx_if #(.DATA_WIDTH(32), .FIFO_CNT_WIDTH(3)) bus ();
  fifo_drain_tx #(.DATA_WIDTH(32), .FIFO_CNT_WIDTH(3), .BURST_LEN(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int rd_cnt = 0;
  int vld_seen = 0;
  logic [7:0] exp_q[$];
  logic push;
  logic [31:0] push_w;
  logic [31:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  logic hold_prev;
  logic [7:0] hold_data;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] w);
    push = 1'b1;
    push_w = w;
    step();
    push = 1'b0;
  endtask
  task automatic exp_pkt(input logic [31:0] w [4], input int n);
    logic [7:0] cs = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[i][8*b +: 8]);
        cs ^= w[i][8*b +: 8];
      end
    if (CS == 1) exp_q.push_back(cs);
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.pkt_done; i++) step();
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || bus.abort) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_w;
        wp <= wp + 3'd1;
      end
      if (bus.fifo_rd && cnt != 4'd0) rp <= rp + 3'd1;
      cnt <= cnt + 4'(push) - 4'(bus.fifo_rd && cnt != 4'd0);
    end
  end
  assign bus.fifo_data = mem[rp];
  assign bus.fifo_rdy = cnt != 4'd0;
  assign bus.fifo_size = cnt[2:0];
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_vld", 32'(bus.tx_vld), 32'd1);
      check("hold_data", 32'(bus.tx_data), 32'(hold_data));
    end
    hold_prev = bus.tx_vld && !bus.tx_rdy && !bus.abort && !rst;
    hold_data = bus.tx_data;
    if (bus.tx_vld) vld_seen++;
    if (bus.fifo_rd) rd_cnt++;
    if (bus.tx_vld && bus.tx_rdy && !rst) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    logic [31:0] wv [4];
    int t0;
    rst = 1'b1;
    push = 1'b0;
    push_w = '0;
    hold_prev = 1'b0;
    hold_data = '0;
    bus.drain_req = 1'b0;
    bus.abort = 1'b0;
    bus.tx_rdy = 1'b0;
    repeat (3) step();
    check("rst_tx_vld", 32'(bus.tx_vld), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_fifo_rd", 32'(bus.fifo_rd), 0);
    check("rst_pkt_done", 32'(bus.pkt_done), 0);
    check("rst_pkt_abort", 32'(bus.pkt_abort), 0);
    rst = 1'b0;
    step();
    // auto burst with the sink always ready
    bus.tx_rdy = 1'b1;
    wv = '{32'h1, 32'h2, 32'h3, 32'h4};
    exp_pkt(wv, 4);
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) push_word(wv[i]);
    for (int i = 0; i < 20 && !bus.busy; i++) step();
    check("burst_start", 32'(bus.busy), 1);
    check("burst_first_hdr", 32'(bus.tx_data), 32'hA5);
    t0 = cyc;
    wait_done(100);
    check("burst_done", 32'(bus.pkt_done), 1);
    check("burst_len", 32'(cyc - t0), 32'(22 + CS));
    check("burst_rd", 32'(rd_cnt), 4);
    check("burst_sb", 32'(exp_q.size()), 0);
    step();
    check("burst_done_pulse", 32'(bus.pkt_done), 0);
    // drain request with a partial FIFO
    wv = '{32'h11223344, 32'h55667788, 32'h0, 32'h0};
    exp_pkt(wv, 2);
    rd_cnt = 0;
    push_word(wv[0]);
    push_word(wv[1]);
    repeat (2) step();
    check("drain_idle_before", 32'(bus.busy), 0);
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
    check("drain_start", 32'(bus.busy), 1);
    wait_done(100);
    check("drain_done", 32'(bus.pkt_done), 1);
    check("drain_busy", 32'(bus.busy), 0);
    check("drain_rd", 32'(rd_cnt), 2);
    check("drain_sb", 32'(exp_q.size()), 0);
    step();
    // backpressure: sink ready toggles every cycle
    wv = '{32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5, 32'hFFFF0000};
    exp_pkt(wv, 4);
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) push_word(wv[i]);
    for (int i = 0; i < 300 && !bus.pkt_done; i++) begin
      bus.tx_rdy = ~bus.tx_rdy;
      step();
    end
    check("bp_done", 32'(bus.pkt_done), 1);
    check("bp_rd", 32'(rd_cnt), 4);
    check("bp_sb", 32'(exp_q.size()), 0);
    bus.tx_rdy = 1'b1;
    step();
    // abort during the second word
    wv = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h04);
    for (int b = 3; b >= 0; b--) exp_q.push_back(wv[0][8*b +: 8]);
    exp_q.push_back(wv[1][31:24]);
    rx_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) push_word(wv[i]);
    for (int i = 0; i < 60 && rx_cnt < 7; i++) step();
    check("abort_reach", 32'(rx_cnt), 7);
    bus.abort = 1'b1;
    bus.tx_rdy = 1'b0;
    step();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_tx_vld", 32'(bus.tx_vld), 0);
    check("abort_pulse", 32'(bus.pkt_abort), 1);
    check("abort_fifo_rd", 32'(bus.fifo_rd), 0);
    bus.tx_rdy = 1'b1;
    repeat (5) step();
    check("abort_pulse_end", 32'(bus.pkt_abort), 0);
    check("abort_rd", 32'(rd_cnt), 2);
    check("abort_sb", 32'(exp_q.size()), 0);
    // drain request with the FIFO empty
    vld_seen = 0;
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
    repeat (5) step();
    check("empty_vld", 32'(vld_seen), 0);
    check("empty_busy", 32'(bus.busy), 0);
    check("empty_rd", 32'(rd_cnt), 2);
    // reset in the middle of a packet
    wv = '{32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0BADBEEF};
    exp_pkt(wv, 4);
    rx_cnt = 0;
    for (int i = 0; i < 4; i++) push_word(wv[i]);
    for (int i = 0; i < 60 && rx_cnt < 5; i++) step();
    check("rst_reach", 32'(rx_cnt), 5);
    rst = 1'b1;
    bus.tx_rdy = 1'b0;
    exp_q.delete();
    step();
    check("mid_rst_tx_vld", 32'(bus.tx_vld), 0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 0);
    check("mid_rst_fifo_rd", 32'(bus.fifo_rd), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_pkt_done", 32'(bus.pkt_done), 0);
    check("mid_rst_pkt_abort", 32'(bus.pkt_abort), 0);
    rst = 1'b0;
    bus.tx_rdy = 1'b1;
    repeat (3) step();
    check("post_rst_busy", 32'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
